// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned OP_W    = 3;

  typedef logic [OP_W-1:0] alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_XOR = 3'b100;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels between two requesters and the ALU arbiter.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64
);

  logic                req0_valid;
  logic                req0_ready;
  logic [WORDSIZE-1:0] req0_a;
  logic [WORDSIZE-1:0] req0_b;
  alu_op_t             req0_op;

  logic                req1_valid;
  logic                req1_ready;
  logic [WORDSIZE-1:0] req1_a;
  logic [WORDSIZE-1:0] req1_b;
  alu_op_t             req1_op;

  logic                resp0_valid;
  logic                resp0_ready;
  logic                resp1_valid;
  logic                resp1_ready;
  logic [WORDSIZE-1:0] resp_result;
  logic                resp_overflow;

  // Requester side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_result, resp_overflow
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_result, resp_overflow
  );

endinterface

// File: rtl/alu.sv
// Combinational integer ALU with signed overflow flag for add/sub.
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  input  alu_op_t             op,
  output logic [WORDSIZE-1:0] result,
  output logic                overflow
);

  localparam int unsigned MSB = WORDSIZE - 1;

  // Operation select; undefined codes yield zero.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    unique case (op)
      ALU_ADD: begin
        result   = a + b;
        overflow = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result   = a - b;
        overflow = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  assign any   = |valid;
  assign grant = (valid == 2'b11) ? ~last : valid[1];

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters; one operation in flight, round-robin grants.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WORDSIZE = 64
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic         busy
);

  state_t              state;
  state_t              state_next;
  logic                last_grant;
  logic                owner;
  logic                grant;
  logic                any;
  logic                accept;
  logic                resp_done;
  logic [WORDSIZE-1:0] op_a;
  logic [WORDSIZE-1:0] op_b;
  alu_op_t             op_code;
  logic [WORDSIZE-1:0] alu_result;
  logic                alu_overflow;

  rr_pick2 u_pick (
    .valid ({bus.req1_valid, bus.req0_valid}),
    .last  (last_grant),
    .grant (grant),
    .any   (any)
  );

  // ALU sees only the captured operands, never the requester buses.
  alu #(.WORDSIZE(WORDSIZE)) u_alu (
    .a        (op_a),
    .b        (op_b),
    .op       (op_code),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  // Ready is only offered from IDLE, to the picked requester.
  assign bus.req0_ready = (state == ST_IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = (state == ST_IDLE) && bus.req1_valid &&  grant;
  assign accept         = (state == ST_IDLE) && any;
  assign resp_done      = (state == ST_RESP) &&
                          (owner ? (bus.resp1_valid && bus.resp1_ready)
                                 : (bus.resp0_valid && bus.resp0_ready));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept)    state_next = ST_EXEC;
      ST_EXEC:                state_next = ST_RESP;
      ST_RESP: if (resp_done) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // Operand capture, result capture and registered response/busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant        <= 1'b1;
      owner             <= 1'b0;
      op_a              <= '0;
      op_b              <= '0;
      op_code           <= ALU_ADD;
      bus.resp_result   <= '0;
      bus.resp_overflow <= 1'b0;
      bus.resp0_valid   <= 1'b0;
      bus.resp1_valid   <= 1'b0;
      busy              <= 1'b0;
    end else begin
      if (accept) begin
        op_a       <= grant ? bus.req1_a  : bus.req0_a;
        op_b       <= grant ? bus.req1_b  : bus.req0_b;
        op_code    <= grant ? bus.req1_op : bus.req0_op;
        owner      <= grant;
        last_grant <= grant;
      end
      if (state == ST_EXEC) begin
        bus.resp_result   <= alu_result;
        bus.resp_overflow <= alu_overflow;
      end
      // Valid rises one cycle into RESP and drops on the handshake edge.
      bus.resp0_valid <= (state == ST_RESP) && (state_next == ST_RESP) && !owner;
      bus.resp1_valid <= (state == ST_RESP) && (state_next == ST_RESP) &&  owner;
      busy            <= (state_next != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner cases, random vs. model.
module tb_alu_arbiter;

  localparam int unsigned W = 64;

  logic clk;
  logic reset;
  logic busy;

  alu_arbiter_if #(.WORDSIZE(W)) bus ();

  alu_arbiter #(.WORDSIZE(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          who;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] exp_r;
    logic        exp_o;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int who, input logic v, input logic [63:0] a,
                           input logic [63:0] b, input logic [2:0] op);
    if (who == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    end
  endtask

  function automatic logic rdy(input int who);
    return (who == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rvld(input int who);
    return (who == 0) ? bus.resp0_valid : bus.resp1_valid;
  endfunction

  // Reference ALU: arithmetic done one bit wider, overflow when the extra bit disagrees.
  function automatic void model_alu(input logic [63:0] a, input logic [63:0] b,
                                    input logic [2:0] op, output logic [63:0] r,
                                    output logic o);
    logic [64:0] wide;
    wide = '0;
    r    = '0;
    o    = 1'b0;
    case (op)
      3'd0: begin wide = {a[63], a} + {b[63], b}; r = wide[63:0]; o = wide[64] ^ wide[63]; end
      3'd1: begin wide = {a[63], a} - {b[63], b}; r = wide[63:0]; o = wide[64] ^ wide[63]; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = '0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One isolated transaction; operands are scrambled right after the accept edge.
  task automatic run_single(input string name, input vec_t v);
    int oth;
    oth = 1 - v.who;
    drive_req(v.who, 1'b1, v.a, v.b, v.op);
    drive_req(oth, 1'b0, '0, '0, '0);
    #1;
    chk({name, "_ready"}, 64'(rdy(v.who)), 64'd1);
    chk({name, "_other_ready"}, 64'(rdy(oth)), 64'd0);
    step();
    drive_req(v.who, 1'b0, ~v.a, ~v.b, 3'd2);
    chk({name, "_busy"}, 64'(busy), 64'd1);
    chk({name, "_early_valid0"}, 64'(rvld(v.who)), 64'd0);
    step();
    chk({name, "_early_valid1"}, 64'(rvld(v.who)), 64'd0);
    step();
    chk({name, "_valid"}, 64'(rvld(v.who)), 64'd1);
    chk({name, "_other_valid"}, 64'(rvld(oth)), 64'd0);
    chk({name, "_result"}, bus.resp_result, v.exp_r);
    chk({name, "_ovf"}, 64'(bus.resp_overflow), 64'(v.exp_o));
    step();
    chk({name, "_valid_drop"}, 64'(rvld(v.who)), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int          grants [$];
    int          gcyc [$];
    logic        m_out, m_last, m_owner, acc_pend, hs_pend, acc_who;
    int          m_age;
    logic [63:0] m_r, acc_r;
    logic        m_o, acc_o;
    logic        rv0, rv1, g, e_rdy0, e_rdy1, e_rv0, e_rv1;
    logic [63:0] ra0, rb0, ra1, rb1;
    logic [2:0]  op0, op1;

    vecs[0] = '{0, 64'h1, 64'h2, 3'd0, 64'h3, 1'b0};
    vecs[1] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 3'd0, 64'h8000_0000_0000_0000, 1'b1};
    vecs[2] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd0, 64'h0, 1'b0};
    vecs[3] = '{1, 64'h0, 64'h1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4] = '{0, 64'h8000_0000_0000_0000, 64'h1, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5] = '{1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'd2, 64'hF000_F000_F000_F000, 1'b0};
    vecs[6] = '{0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'd3, 64'hFFF0_FFF0_FFF0_FFF0, 1'b0};
    vecs[7] = '{1, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 3'd4, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0};
    vecs[8] = '{0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd0, 64'h0, 1'b1};

    reset = 1'b1;
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    bus.resp0_ready = 1'b1;
    bus.resp1_ready = 1'b1;
    do_reset();

    // Reset state.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp0_valid", 64'(bus.resp0_valid), 64'd0);
    chk("rst_resp1_valid", 64'(bus.resp1_valid), 64'd0);
    chk("rst_result", bus.resp_result, 64'd0);
    chk("rst_ovf", 64'(bus.resp_overflow), 64'd0);
    chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
    chk("rst_ready1", 64'(bus.req1_ready), 64'd0);

    // Table-driven single transactions.
    for (int i = 0; i < 9; i++) run_single($sformatf("vec%0d", i), vecs[i]);

    // Contention fairness from a fresh reset.
    do_reset();
    drive_req(0, 1'b1, 64'h1, 64'h2, 3'd0);
    drive_req(1, 1'b1, 64'h5, 64'h6, 3'd0);
    #1;
    for (int c = 0; c < 24; c++) begin
      if (bus.req0_ready) begin grants.push_back(0); gcyc.push_back(c); end
      if (bus.req1_ready) begin grants.push_back(1); gcyc.push_back(c); end
      if (bus.resp0_valid) chk("cont_result0", bus.resp_result, 64'h3);
      if (bus.resp1_valid) chk("cont_result1", bus.resp_result, 64'hB);
      step();
    end
    chk("cont_count", 64'(grants.size()), 64'd6);
    for (int i = 0; i < grants.size(); i++) begin
      chk($sformatf("cont_grant%0d", i), 64'(grants[i]), 64'(i % 2));
      if (i > 0) chk($sformatf("cont_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd4);
    end
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 5; i++) step();

    // Backpressure: held response blocks the waiting requester.
    bus.resp0_ready = 1'b0;
    drive_req(0, 1'b1, 64'h10, 64'h20, 3'd0);
    #1;
    chk("bp_ready0", 64'(bus.req0_ready), 64'd1);
    step();
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b1, 64'h5, 64'h6, 3'd0);
    #1;
    chk("bp_ready1_exec", 64'(bus.req1_ready), 64'd0);
    step();
    chk("bp_ready1_resp", 64'(bus.req1_ready), 64'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 64'(bus.resp0_valid), 64'd1);
      chk("bp_hold_result", bus.resp_result, 64'h30);
      chk("bp_hold_ready1", 64'(bus.req1_ready), 64'd0);
      step();
    end
    bus.resp0_ready = 1'b1;
    #1;
    chk("bp_pre_hs_valid", 64'(bus.resp0_valid), 64'd1);
    step();
    bus.resp0_ready = 1'b0;
    #1;
    chk("bp_post_hs_valid", 64'(bus.resp0_valid), 64'd0);
    chk("bp_post_hs_busy", 64'(busy), 64'd0);
    chk("bp_post_hs_ready1", 64'(bus.req1_ready), 64'd1);
    step();
    drive_req(1, 1'b0, '0, '0, '0);
    chk("bp_req1_busy", 64'(busy), 64'd1);
    step();
    step();
    chk("bp_resp1_valid", 64'(bus.resp1_valid), 64'd1);
    chk("bp_resp1_result", bus.resp_result, 64'hB);
    step();
    chk("bp_resp1_drop", 64'(bus.resp1_valid), 64'd0);
    bus.resp0_ready = 1'b1;

    // Reset during EXEC discards the op and restores requester-0 priority.
    drive_req(0, 1'b1, 64'h1, 64'h2, 3'd0);
    #1;
    chk("rmid_ready0", 64'(bus.req0_ready), 64'd1);
    step();
    drive_req(0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_resp0", 64'(bus.resp0_valid), 64'd0);
    chk("rmid_resp1", 64'(bus.resp1_valid), 64'd0);
    chk("rmid_ready0_off", 64'(bus.req0_ready), 64'd0);
    chk("rmid_ready1_off", 64'(bus.req1_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rmid_no_resp", 64'(bus.resp0_valid | bus.resp1_valid), 64'd0);
      chk("rmid_still_idle", 64'(busy), 64'd0);
    end
    drive_req(0, 1'b1, 64'h1, 64'h2, 3'd0);
    drive_req(1, 1'b1, 64'h5, 64'h6, 3'd0);
    #1;
    chk("rmid_tie_ready0", 64'(bus.req0_ready), 64'd1);
    chk("rmid_tie_ready1", 64'(bus.req1_ready), 64'd0);
    step();
    drive_req(0, 1'b0, '0, '0, '0);
    drive_req(1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) step();

    // Random traffic against a transaction-level model.
    do_reset();
    m_out = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_age = 0;
    m_r = '0; m_o = 1'b0; acc_pend = 1'b0; hs_pend = 1'b0; acc_who = 1'b0;
    acc_r = '0; acc_o = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rv0 = ($urandom_range(0, 9) < 6);
      rv1 = ($urandom_range(0, 9) < 6);
      ra0 = {$urandom(), $urandom()}; rb0 = {$urandom(), $urandom()};
      ra1 = {$urandom(), $urandom()}; rb1 = {$urandom(), $urandom()};
      op0 = 3'($urandom_range(0, 4)); op1 = 3'($urandom_range(0, 4));
      drive_req(0, rv0, ra0, rb0, op0);
      drive_req(1, rv1, ra1, rb1, op1);
      bus.resp0_ready = 1'($urandom_range(0, 1));
      bus.resp1_ready = 1'($urandom_range(0, 1));
      #1;
      g      = (rv0 && rv1) ? !m_last : rv1;
      e_rdy0 = !m_out && rv0 && !g;
      e_rdy1 = !m_out && rv1 &&  g;
      e_rv0  = m_out && (m_age >= 2) && !m_owner;
      e_rv1  = m_out && (m_age >= 2) &&  m_owner;
      chk("rnd_ready0", 64'(bus.req0_ready), 64'(e_rdy0));
      chk("rnd_ready1", 64'(bus.req1_ready), 64'(e_rdy1));
      chk("rnd_resp0", 64'(bus.resp0_valid), 64'(e_rv0));
      chk("rnd_resp1", 64'(bus.resp1_valid), 64'(e_rv1));
      chk("rnd_busy", 64'(busy), 64'(m_out));
      if (e_rv0 || e_rv1) begin
        chk("rnd_result", bus.resp_result, m_r);
        chk("rnd_ovf", 64'(bus.resp_overflow), 64'(m_o));
      end
      acc_pend = e_rdy0 || e_rdy1;
      acc_who  = e_rdy1;
      if (e_rdy0) model_alu(ra0, rb0, op0, acc_r, acc_o);
      if (e_rdy1) model_alu(ra1, rb1, op1, acc_r, acc_o);
      hs_pend = (e_rv0 && bus.resp0_ready) || (e_rv1 && bus.resp1_ready);
      step();
      if (hs_pend) m_out = 1'b0;
      else if (m_out) m_age++;
      if (acc_pend) begin
        m_out = 1'b1; m_age = 0; m_owner = acc_who; m_last = acc_who;
        m_r = acc_r; m_o = acc_o;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters, for example the integer execute path and the address-generation path.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. Operands are registered into the ALU and the result is registered out.
- At most one operation is in flight at a time, which keeps the ALU's combinational path isolated from requester logic.

Parameters:
- WORDSIZE, 64, operand/result width; passed through to the internal `alu`.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 presents an operation
- req0_ready  output  1  arbiter accepts requester 0's operation this cycle
- req0_a  input  WORDSIZE  requester 0 operand A
- req0_b  input  WORDSIZE  requester 0 operand B
- req0_op  input  3  requester 0 ALU operation code
- req1_valid / req1_ready / req1_a / req1_b / req1_op: same as requester 0, for requester 1
- resp0_valid  output  1  result for requester 0 is available
- resp0_ready  input  1  requester 0 consumes its result
- resp1_valid  output  1  result for requester 1 is available
- resp1_ready  input  1  requester 1 consumes its result
- resp_result  output  WORDSIZE  registered ALU result (shared bus, qualified by respN_valid)
- resp_overflow  output  1  registered ALU overflow flag
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, wins over every other event):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie), owner=0.
  - Operand/op/result registers = 0.
  - All ready/valid outputs = 0; busy=0.
- State IDLE:
  - grant = the single valid requester if only one is valid.
  - If both are valid, grant = the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && (grant==N). Ready depends combinationally on valid; no ready goes high in any other state.
  - On reqN_valid && reqN_ready: latch a/b/op into op_a/op_b/op_code, set owner=N and last_grant=N, go to EXEC.
  - If no valid: stay in IDLE, last_grant unchanged.
- State EXEC (exactly 1 cycle):
  - The `alu` is driven only from op_a/op_b/op_code, never directly from requester inputs.
  - At the end of the cycle, capture alu.result into resp_result and alu.overflow into resp_overflow, then go to RESP.
- State RESP:
  - respN_valid = 1 for N==owner only.
  - resp_result and resp_overflow stay stable until the handshake.
  - On respN_ready (N==owner): go to IDLE. The non-owner's resp_ready is ignored.
- Latency and throughput:
  - Request accepted at edge k; EXEC runs in cycle k+1; respN_valid rises after edge k+2.
  - With resp_ready held high, the next accept is at edge k+4, giving peak throughput of 1 op / 4 cycles.
- Backpressure: a response can be held indefinitely. New requests are not accepted while in RESP, and the non-owner's request waits with ready=0.
- Op codes: forwarded unmodified to `alu`. Encoding 000 = add; undefined codes give whatever `alu` produces.
- After the handshake, resp_result retains its last value; respN_valid is the only qualifier.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is issued, and the arbiter returns to IDLE next cycle.
- Requester inputs may change while not accepted; only values present at the accept edge are used.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2
  - ALU op-code constants (ALU_ADD=3'b000, …)
  - NUM_REQ=2
- Sub-modules:
  - Instantiates the existing `alu` as-is.
  - One natural helper: `rr_pick2`, a combinational 2-way round-robin picker with inputs valid[1:0] and last and outputs grant and any. Keeps the FSM file free of priority logic.

Test Plan:
- Single request: req0 a=0x1, b=0x2, op=000, resp0_ready=1 → req0_ready high in the same cycle; resp0_valid high two edges after accept; resp_result=0x3; resp_overflow=0; resp1_valid stays 0.
- Contention fairness: both reqs valid continuously (req0 add 1+2, req1 add 5+6), responses always ready → grants alternate 0,1,0,1; results alternate 0x3 and 0xB; each requester receives one op per 8 cycles.
- Overflow: req1 a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, op=000 → resp_result=0x8000_0000_0000_0000, resp_overflow=1, on resp1_valid.
- Backpressure: req0 completes with resp0_ready=0 for 5 cycles while req1_valid=1 → resp0_valid and resp_result stay stable and req1_ready=0 throughout; after resp0_ready pulses, the state returns to IDLE and req1 is accepted next cycle.
- Reset mid-op: assert reset during EXEC → next cycle all valid/ready outputs are 0, busy=0, and no response appears; the first request afterwards with both valid is granted to req0.
- Operand isolation: change req0_a/req0_b on the cycle after accept → the result reflects the values at the accept edge.
